// File: rtl/conv_pool_mc.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pool_mc
//  Purpose  : Multi-channel tile engine. For each of NUM_TILES 4x4 tiles read
//             from the tile memory it computes a 3x3 convolution summed over
//             NUM_CH channels (2x2 result), pools it to one value (max or
//             average), applies optional ReLU, an arithmetic right shift and
//             saturation to [0, 2^PIX_W-1], and writes one pixel per tile.
//  Ports    : clk, rst        - clock (rising edge), async active-high reset
//             start           - run request, accepted only in IDLE
//             pool_mode       - 0 max / 1 average (latched on start)
//             relu_en, shift  - post-processing config (latched on start)
//             image_tile      - tile data from memory, RD_LAT after input_re
//             kernel          - 3x3 taps per channel (latched on start)
//             input_re/addr   - tile memory read strobe and address
//             output_we/addr  - result write strobe and address, y = data
//             busy, done      - run in progress / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module conv_pool_mc #(
  parameter int NUM_CH    = 3,
  parameter int PIX_W     = 8,
  parameter int KER_W     = 8,
  parameter int ADDR_W    = 16,
  parameter int NUM_TILES = 65025,
  parameter int RD_LAT    = 1,
  parameter int SHIFT_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       pool_mode,
  input  logic                       relu_en,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic [NUM_CH*16*PIX_W-1:0] image_tile,
  input  logic [NUM_CH*9*KER_W-1:0]  kernel,
  output logic                       input_re,
  output logic [ADDR_W-1:0]          input_addr,
  output logic                       output_we,
  output logic [ADDR_W-1:0]          output_addr,
  output logic [PIX_W-1:0]           y,
  output logic                       busy,
  output logic                       done
);

  localparam int PROD_W = PIX_W + KER_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(9 * NUM_CH);
  // Pooling adds 4 results, so two guard bits keep the average sum exact.
  localparam int POOL_W = ACC_W + 2;
  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int TILE_W = NUM_CH * 16 * PIX_W;
  localparam int KERN_W = NUM_CH * 9 * KER_W;

  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(NUM_TILES - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CONV  = 3'd3,
    S_POOL  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         cnt_q, cnt_d;
  logic [WCNT_W-1:0]         wait_q, wait_d;
  logic [1:0]                win_q, win_d;
  logic [TILE_W-1:0]         tile_q, tile_d;
  logic [KERN_W-1:0]         kernel_q, kernel_d;
  logic                      mode_q, mode_d;
  logic                      relu_q, relu_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic signed [ACC_W-1:0]   res_q [4];
  logic signed [ACC_W-1:0]   res_d [4];
  logic [PIX_W-1:0]          y_q, y_d;
  logic [ADDR_W-1:0]         in_addr_q, in_addr_d;
  logic [ADDR_W-1:0]         out_addr_q, out_addr_d;

  // --------------------------------------------------------------------------
  // Convolution of the window selected by win_q (row = win_q[1], col = win_q[0])
  // --------------------------------------------------------------------------
  logic signed [PIX_W:0]     px;
  logic signed [KER_W-1:0]   kw;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   conv_acc;
  int                        pidx;

  always_comb begin
    conv_acc = '0;
    px       = '0;
    kw       = '0;
    prod     = '0;
    pidx     = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          pidx     = c * 16 + (int'(win_q[1]) + i) * 4 + int'(win_q[0]) + j;
          // Pixels are unsigned: prepend a zero so the signed multiply is exact.
          px       = {1'b0, tile_q[pidx*PIX_W +: PIX_W]};
          kw       = kernel_q[(c*9 + i*3 + j)*KER_W +: KER_W];
          prod     = px * kw;
          conv_acc = conv_acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pool, ReLU, requantisation shift and saturation
  // --------------------------------------------------------------------------
  logic signed [POOL_W-1:0] e0, e1, e2, e3;
  logic signed [POOL_W-1:0] max01, max23, pool_max, pool_sum, pool_avg;
  logic signed [POOL_W-1:0] pool_val, relu_val, shr_val;
  logic [PIX_W-1:0]         sat_val;

  always_comb begin
    e0       = {{2{res_q[0][ACC_W-1]}}, res_q[0]};
    e1       = {{2{res_q[1][ACC_W-1]}}, res_q[1]};
    e2       = {{2{res_q[2][ACC_W-1]}}, res_q[2]};
    e3       = {{2{res_q[3][ACC_W-1]}}, res_q[3]};
    max01    = (e0 > e1) ? e0 : e1;
    max23    = (e2 > e3) ? e2 : e3;
    pool_max = (max01 > max23) ? max01 : max23;
    pool_sum = e0 + e1 + e2 + e3;
    // Arithmetic shift rounds toward minus infinity for negative sums.
    pool_avg = pool_sum >>> 2;
    pool_val = mode_q ? pool_avg : pool_max;
    relu_val = (relu_q && pool_val[POOL_W-1]) ? '0 : pool_val;
    shr_val  = relu_val >>> shift_q;
    // Negative results clamp to 0 even without ReLU; any set bit above the
    // pixel field means the value exceeds the output range.
    if (shr_val[POOL_W-1]) begin
      sat_val = '0;
    end else if (|shr_val[POOL_W-2:PIX_W]) begin
      sat_val = '1;
    end else begin
      sat_val = shr_val[PIX_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = '0;
    win_d      = win_q;
    tile_d     = tile_q;
    kernel_d   = kernel_q;
    mode_d     = mode_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    res_d      = res_q;
    y_d        = y_q;
    in_addr_d  = in_addr_q;
    out_addr_d = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = pool_mode;
          relu_d    = relu_en;
          shift_d   = shift;
          kernel_d  = kernel;
          cnt_d     = '0;
          in_addr_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The memory presents the tile during the last wait cycle only.
        if (wait_q == WAIT_LAST) begin
          tile_d  = image_tile;
          win_d   = 2'd0;
          state_d = S_CONV;
        end else begin
          wait_d = wait_q + WCNT_W'(1);
        end
      end
      S_CONV: begin
        res_d[win_q] = conv_acc;
        win_d        = win_q + 2'd1;
        if (win_q == 2'd3) begin
          state_d = S_POOL;
        end
      end
      S_POOL: begin
        y_d        = sat_val;
        out_addr_d = cnt_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        // Compare before incrementing so a full 2^ADDR_W run never wraps.
        if (cnt_q == LAST_TILE) begin
          state_d = S_DONE;
        end else begin
          cnt_d     = cnt_q + ADDR_W'(1);
          in_addr_d = cnt_q + ADDR_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      win_q      <= '0;
      tile_q     <= '0;
      kernel_q   <= '0;
      mode_q     <= 1'b0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        res_q[k] <= '0;
      end
      y_q        <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      win_q      <= win_d;
      tile_q     <= tile_d;
      kernel_q   <= kernel_d;
      mode_q     <= mode_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      res_q      <= res_d;
      y_q        <= y_d;
      in_addr_q  <= in_addr_d;
      out_addr_q <= out_addr_d;
    end
  end

  // Strobes decode straight from the state register so they drop to 0 the
  // moment reset forces IDLE.
  assign input_re    = (state_q == S_FETCH);
  assign output_we   = (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign input_addr  = in_addr_q;
  assign output_addr = out_addr_q;
  assign y           = y_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_pool_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_pool_mc
//  Purpose  : Self-checking bench. Instance A (3 channels, RD_LAT=1, 8 tiles)
//             runs a table of directed vectors; instance B (1 channel,
//             RD_LAT=3, ADDR_W=2, 4 tiles = full address space) checks the
//             longer tile period and the all-ones last address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pool_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic         a_start, a_mode, a_relu;
  logic [3:0]   a_shift;
  logic [383:0] a_tile, a_tile_val;
  logic [215:0] a_kernel;
  logic         a_re, a_we, a_busy, a_done;
  logic [15:0]  a_iaddr, a_oaddr;
  logic [7:0]   a_y;
  logic         a_vld;

  conv_pool_mc #(.NUM_CH(3), .PIX_W(8), .KER_W(8), .ADDR_W(16), .NUM_TILES(8),
                 .RD_LAT(1), .SHIFT_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .pool_mode(a_mode), .relu_en(a_relu),
    .shift(a_shift), .image_tile(a_tile), .kernel(a_kernel),
    .input_re(a_re), .input_addr(a_iaddr), .output_we(a_we), .output_addr(a_oaddr),
    .y(a_y), .busy(a_busy), .done(a_done));

  // Tile memory model: valid data only in the cycle RD_LAT after the read.
  always @(posedge clk) a_vld <= rst ? 1'b0 : a_re;
  assign a_tile = a_vld ? a_tile_val : '0;

  // ---------------- instance B ----------------
  logic         b_start;
  logic [127:0] b_tile;
  logic [71:0]  b_kernel;
  logic         b_re, b_we, b_busy, b_done;
  logic [1:0]   b_iaddr, b_oaddr;
  logic [7:0]   b_y;
  logic [2:0]   b_vld;

  conv_pool_mc #(.NUM_CH(1), .PIX_W(8), .KER_W(8), .ADDR_W(2), .NUM_TILES(4),
                 .RD_LAT(3), .SHIFT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pool_mode(1'b1), .relu_en(1'b0),
    .shift(4'd1), .image_tile(b_tile), .kernel(b_kernel),
    .input_re(b_re), .input_addr(b_iaddr), .output_we(b_we), .output_addr(b_oaddr),
    .y(b_y), .busy(b_busy), .done(b_done));

  always @(posedge clk) b_vld <= rst ? 3'b000 : {b_vld[1:0], b_re};
  assign b_tile = b_vld[2] ? {16{8'h10}} : '0;

  // ---------------- vector table ----------------
  typedef struct {
    bit         special;  // 1: ch0 windows give 100,200,300,400, other kernels 0
    logic [7:0] pix;
    logic [7:0] tap;
    bit         mode;
    bit         relu;
    logic [3:0] sh;
    logic [7:0] exp_y;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic load_a(input vec_t v);
    logic [7:0] spec_pix [4];
    a_mode  = v.mode;
    a_relu  = v.relu;
    a_shift = v.sh;
    if (v.special) begin
      spec_pix[0] = 8'd50;  spec_pix[1] = 8'd100;
      spec_pix[2] = 8'd150; spec_pix[3] = 8'd200;
      a_tile_val = {48{8'h77}};
      a_tile_val[0*8 +: 8] = spec_pix[0];
      a_tile_val[1*8 +: 8] = spec_pix[1];
      a_tile_val[4*8 +: 8] = spec_pix[2];
      a_tile_val[5*8 +: 8] = spec_pix[3];
      a_kernel = '0;
      a_kernel[7:0] = 8'd2;
    end else begin
      a_tile_val = {48{v.pix}};
      a_kernel   = {27{v.tap}};
    end
  endtask

  // Full run on instance A with per-cycle protocol checks.
  task automatic run_a(input vec_t v, input int id, input bit poke);
    int cyc, last_re, n_re, n_wr;
    bit fin;
    load_a(v);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    cyc = 0; last_re = 0; n_re = 0; n_wr = 0; fin = 0;
    while (!fin && cyc < 300) begin
      a_start = poke && (cyc == 20);
      if (a_re) begin
        chk(a_iaddr == 16'(n_re), $sformatf("v%0d input_addr", id), a_iaddr, n_re);
        if (n_re > 0) chk(cyc - last_re == 8, $sformatf("v%0d tile period", id), cyc - last_re, 8);
        last_re = cyc;
        n_re++;
      end
      if (a_we) begin
        chk(a_y == v.exp_y, $sformatf("v%0d y", id), a_y, v.exp_y);
        chk(a_oaddr == 16'(n_wr), $sformatf("v%0d output_addr", id), a_oaddr, n_wr);
        chk(cyc - last_re == 7, $sformatf("v%0d write latency", id), cyc - last_re, 7);
        n_wr++;
      end
      if (a_done) begin
        chk(n_wr == 8 && n_re == 8, $sformatf("v%0d write count", id), n_wr, 8);
        chk(a_busy == 1'b0, $sformatf("v%0d busy in done", id), a_busy, 0);
        fin = 1;
      end else begin
        chk(a_busy == 1'b1, $sformatf("v%0d busy", id), a_busy, 1);
        @(negedge clk);
        cyc++;
      end
    end
    a_start = 1'b0;
    if (!fin) chk(1'b0, $sformatf("v%0d done timeout", id), cyc, 300);
    // Start in the DONE cycle must be ignored; done is one cycle wide.
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    chk(a_done == 1'b0, $sformatf("v%0d done width", id), a_done, 0);
    chk(a_busy == 1'b0 && a_re == 1'b0, $sformatf("v%0d start in done", id), a_busy, 0);
    @(negedge clk);
    chk(a_re == 1'b0 && a_busy == 1'b0, $sformatf("v%0d idle after done", id), a_re, 0);
    chk(a_y == v.exp_y, $sformatf("v%0d y hold", id), a_y, v.exp_y);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last_re, n_re, n_wr;
    bit fin;
    //            spec pix    tap    mode relu sh     exp
    vecs[0]  = '{0, 8'h01, 8'h01, 0, 0, 4'd0,  8'd27};
    vecs[1]  = '{0, 8'hFF, 8'hFF, 0, 0, 4'd0,  8'd0};
    vecs[2]  = '{0, 8'hFF, 8'hFF, 0, 1, 4'd0,  8'd0};
    vecs[3]  = '{0, 8'hFF, 8'hFF, 1, 0, 4'd0,  8'd0};
    vecs[4]  = '{1, 8'h00, 8'h00, 0, 0, 4'd1,  8'd200};
    vecs[5]  = '{1, 8'h00, 8'h00, 1, 0, 4'd1,  8'd125};
    vecs[6]  = '{1, 8'h00, 8'h00, 1, 0, 4'd0,  8'd250};
    vecs[7]  = '{1, 8'h00, 8'h00, 0, 1, 4'd0,  8'd255};
    vecs[8]  = '{0, 8'hFF, 8'h7F, 0, 0, 4'd0,  8'd255};
    vecs[9]  = '{0, 8'hFF, 8'h7F, 0, 0, 4'd12, 8'd213};
    vecs[10] = '{0, 8'hFF, 8'h7F, 1, 1, 4'd12, 8'd213};
    vecs[11] = '{0, 8'h01, 8'hFE, 0, 1, 4'd0,  8'd0};
    vecs[12] = '{0, 8'h10, 8'h03, 0, 1, 4'd3,  8'd162};
    vecs[13] = '{0, 8'h10, 8'h03, 1, 0, 4'd2,  8'd255};

    a_start = 0; a_mode = 0; a_relu = 0; a_shift = '0; a_tile_val = '0; a_kernel = '0;
    b_start = 0; b_kernel = {9{8'h03}};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk({a_re, a_we, a_busy, a_done} == 4'b0, "reset strobes A", {a_re, a_we, a_busy, a_done}, 0);
    chk(a_iaddr == 0 && a_oaddr == 0, "reset addr A", a_oaddr, 0);
    chk(a_y == 0, "reset y A", a_y, 0);
    chk({b_re, b_we, b_busy, b_done} == 4'b0 && b_y == 0, "reset B", b_y, 0);

    // Table-driven runs; vectors 0 and 12 also pulse start mid-run
    for (int i = 0; i < NV; i++) begin
      run_a(vecs[i], i, (i == 0) || (i == 12));
    end

    // Asynchronous reset during CONV of tile 5
    load_a(vecs[0]);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    cyc = 0;
    while (!(a_re && a_iaddr == 16'd5) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(cyc < 100, "reach tile 5", cyc, 100);
    @(negedge clk);
    @(negedge clk);
    chk(a_busy == 1'b1 && a_y == 8'd27, "pre-reset busy/y", a_y, 27);
    #1 rst = 1'b1;
    #1;
    chk({a_re, a_we, a_busy, a_done} == 4'b0, "async reset strobes", {a_re, a_we, a_busy, a_done}, 0);
    chk(a_iaddr == 0, "async reset input_addr", a_iaddr, 0);
    chk(a_oaddr == 0, "async reset output_addr", a_oaddr, 0);
    chk(a_y == 0, "async reset y", a_y, 0);
    @(negedge clk);
    rst = 1'b0;
    n_wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_we || a_re || a_busy) n_wr++;
    end
    chk(n_wr == 0, "no activity after reset", n_wr, 0);
    run_a(vecs[0], 100, 1'b0);

    // Instance B: RD_LAT=3 and a run covering the whole address space
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    cyc = 0; last_re = 0; n_re = 0; n_wr = 0; fin = 0;
    while (!fin && cyc < 200) begin
      if (b_re) begin
        chk(b_iaddr == 2'(n_re), "B input_addr", b_iaddr, n_re);
        if (n_re > 0) chk(cyc - last_re == 10, "B tile period", cyc - last_re, 10);
        last_re = cyc;
        n_re++;
      end
      if (b_we) begin
        chk(b_y == 8'd216, "B y", b_y, 216);
        chk(b_oaddr == 2'(n_wr), "B output_addr", b_oaddr, n_wr);
        chk(cyc - last_re == 9, "B write latency", cyc - last_re, 9);
        n_wr++;
      end
      if (b_done) begin
        chk(n_wr == 4 && n_re == 4, "B write count", n_wr, 4);
        chk(b_oaddr == 2'b11, "B last address", b_oaddr, 3);
        fin = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk(1'b0, "B done timeout", cyc, 200);
    @(negedge clk);
    chk(b_done == 1'b0 && b_busy == 1'b0 && b_re == 1'b0, "B idle after done", b_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_pool_mc.md
Name: conv_pool_mc

Overview:
- Multi-channel, parametrised successor to the single-tile conv/pool engine.
- Streams NUM_TILES 4x4 tiles from a tile memory, one tile per read. Each tile carries NUM_CH channels.
- Per tile: a 3x3 convolution summed across all channels gives a 2x2 result. This is pooled to one value (max or average), then passed through optional ReLU, a right-shift requantisation and saturation.
- Writes one PIX_W-bit result per tile to the result memory. Sits between the image tile memories and the feature-map result memory, started by the control sequencer.

Parameters:
- NUM_CH, 3, channel count (>=1).
- PIX_W, 8, pixel width, unsigned.
- KER_W, 8, kernel coefficient width, two's complement.
- ADDR_W, 16, tile and result address width.
- NUM_TILES, 65025, tiles per run (1..2^ADDR_W).
- RD_LAT, 1, tile memory read latency in cycles (>=1).
- SHIFT_W, 4, width of the requant shift field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- pool_mode  in  1  0 = max pool, 1 = average pool; latched on start.
- relu_en  in  1  1 = clamp negative pooled value to 0; latched on start.
- shift  in  SHIFT_W  arithmetic right shift applied after pooling; latched on start.
- image_tile  in  NUM_CH*16*PIX_W  tile data. Channel c, pixel (r,col) is at bit offset (c*16 + r*4 + col)*PIX_W.
- kernel  in  NUM_CH*9*KER_W  coefficients. Channel c, tap (i,j) is at bit offset (c*9 + i*3 + j)*KER_W; latched on start.
- input_re  out  1  tile read enable.
- input_addr  out  ADDR_W  tile read address.
- output_we  out  1  result write enable.
- output_addr  out  ADDR_W  result address (equals tile index).
- y  out  PIX_W  result data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - FSM returns to IDLE and the tile counter clears.
  - All outputs go to 0; latched configuration clears.
  - No partial write is issued after reset deasserts.
- Arithmetic widths:
  - Pixels are zero-extended to PIX_W+1 signed; products are PIX_W+KER_W+1 bits.
  - ACC_W = PIX_W+KER_W+1+clog2(9*NUM_CH); no internal overflow is possible.
- Conv output at window (wr,wc), wr,wc in {0,1}: sum over c, i, j of pix[c][wr+i][wc+j] * ker[c][i][j].
- Pool stage:
  - Max mode: signed maximum of the 4 conv results.
  - Average mode: sum of the 4 results, arithmetic shift right by 2 (floor toward -inf).
- Post stage:
  - If relu_en and the value is negative, the value becomes 0.
  - Then arithmetic shift right by shift.
  - Then saturate to [0, 2^PIX_W-1]; negatives map to 0 even with relu_en=0.
- FSM states and transitions:
  - IDLE: wait for start; on start, latch configuration, clear the counter, go to FETCH.
  - FETCH (1 cycle): input_re=1, input_addr=counter.
  - WAIT (RD_LAT cycles): image_tile is captured into the tile register at the rising edge ending the last WAIT cycle.
  - CONV (4 cycles): one window per cycle in order (0,0),(0,1),(1,0),(1,1). Each window's result goes into the 4-entry result register.
  - POOL (1 cycle): pool, ReLU, shift and saturate; result registered into y.
  - WRITE (1 cycle): output_we=1, output_addr=counter, y valid. If counter==NUM_TILES-1 go to DONE; else increment the counter and go to FETCH.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Throughput: 7+RD_LAT cycles per tile, fixed and independent of data.
- Output values outside strobes:
  - input_addr and output_addr hold their last value.
  - input_re and output_we are 0 outside FETCH and WRITE respectively.
  - y holds until the next POOL.
- Start handling:
  - start while busy is ignored.
  - start in the same cycle as DONE is ignored; it is accepted only from IDLE.
- Counter edge cases:
  - NUM_TILES=2^ADDR_W: the last tile address is all ones; the counter does not wrap before DONE.
  - NUM_TILES=1: exactly one FETCH, one WRITE, then DONE.

Test Plan:
- Cross-channel sum: NUM_CH=3, all pixels 0x01, all taps 0x01, max mode, shift=0 -> every y=27, one write per tile, output_addr 0..N-1 in order.
- Negative saturation: pixels 0xFF, taps 0xFF (-1) -> conv=-6885 -> y=0 with relu_en=0 and with relu_en=1.
- Pool modes: one-channel tile whose windows give 100,200,300,400, shift=1.
  - Max mode: y=200.
  - Average mode: (1000>>2)>>1 = y=125.
- Saturation: pixels 0xFF, taps 0x7F, shift=0 -> y=255.
  - Same stimulus with shift=12 -> 3*9*255*127 = 874395 >> 12 = y=213.
- Timing and handshake:
  - RD_LAT=1: cycle 0 of each tile has re=1 and cycle 7 has we=1; the next re follows the cycle after we.
  - done pulses for 1 cycle; start pulsed while busy has no effect.
  - RD_LAT=3 gives a 10-cycle tile period.
- Reset mid-run: rst asserted during CONV of tile 5 -> all outputs 0 immediately (asynchronous).
  - After release, no write occurs until a new start.
  - The rerun begins at address 0.
